// File: rtl/inject_ctrl_pkg.sv
// Shared parameters for the flit injection controller: defaults, FSM encodings, flit fields.
package inject_ctrl_pkg;

  localparam int unsigned DEF_NUM_VC     = 4;
  localparam int unsigned DEF_FLIT_W     = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_CREDITS    = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int unsigned FLIT_HEAD_BIT = 15;
  localparam int unsigned FLIT_TAIL_BIT = 14;
  localparam int unsigned FLIT_DEST_MSB = 13;
  localparam int unsigned FLIT_DEST_LSB = 10;

  // Default-width flit layout as seen on the link
  typedef struct packed {
    logic       head;
    logic       tail;
    logic [3:0] dest;
    logic [9:0] payload;
  } flit_t;

endpackage

// File: rtl/inject_ctrl_if.sv
// Traffic-source and router-link signals of the injection controller.
interface inject_ctrl_if import inject_ctrl_pkg::*; #(
  parameter int unsigned NUM_VC = DEF_NUM_VC,
  parameter int unsigned FLIT_W = DEF_FLIT_W
);
  localparam int unsigned VC_BITS = $clog2(NUM_VC);

  logic               tr_pending;
  logic               tr_deq;
  logic               tr_flit_vld;
  logic [VC_BITS-1:0] tr_vc;
  logic [FLIT_W-1:0]  tr_flit;

  logic               link_valid;
  logic [VC_BITS-1:0] link_vc;
  logic [FLIT_W-1:0]  link_flit;
  logic               credit_in;
  logic [VC_BITS-1:0] credit_vc;

  modport master (
    input  tr_pending, tr_flit_vld, tr_vc, tr_flit, credit_in, credit_vc,
    output tr_deq, link_valid, link_vc, link_flit
  );

  modport slave (
    output tr_pending, tr_flit_vld, tr_vc, tr_flit, credit_in, credit_vc,
    input  tr_deq, link_valid, link_vc, link_flit
  );

endinterface

// File: rtl/inject_ctrl_flit_fifo.sv
// Per-VC show-ahead flit queue; simultaneous write and pop are both honoured.
module flit_fifo import inject_ctrl_pkg::*; #(
  parameter int unsigned FLIT_W     = DEF_FLIT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic [FLIT_W-1:0]             wr_data,
  input  logic                          rd,
  output logic [FLIT_W-1:0]             rd_data_c,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;
  logic [CW-1:0]     count_nxt;

  always_comb begin
    do_rd     = rd && !empty;
    do_wr     = wr && (!full || do_rd);
    count_nxt = count;
    if (do_wr && !do_rd) begin
      count_nxt = count + CW'(1);
    end else if (do_rd && !do_wr) begin
      count_nxt = count - CW'(1);
    end
  end

  // Flags are registered from the next occupancy so they track count exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(FIFO_DEPTH));
      empty <= (count_nxt == CW'(0));
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/inject_ctrl.sv
// Flit injection controller: pulls flits from a traffic source into per-VC queues and
// drains them round-robin onto a credit-flow-controlled router link.
module inject_ctrl import inject_ctrl_pkg::*; #(
  parameter int unsigned NUM_VC     = DEF_NUM_VC,
  parameter int unsigned FLIT_W     = DEF_FLIT_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned CREDITS    = DEF_CREDITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  inject_ctrl_if.master       bus,
  output logic [15:0]         flits_sent,
  output logic                err
);
  localparam int unsigned VC_BITS = $clog2(NUM_VC);
  localparam int unsigned CRD_W   = $clog2(CREDITS + 1);
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic               tr_deq;
  logic               tr_deq_nxt;
  logic               stray_flit_c;
  logic               all_room_c;

  logic [NUM_VC-1:0]  fifo_wr;
  logic [NUM_VC-1:0]  fifo_rd;
  logic [NUM_VC-1:0]  fifo_full;
  logic [NUM_VC-1:0]  fifo_empty;
  logic [FLIT_W-1:0]  fifo_data [NUM_VC];
  logic [CNT_W-1:0]   fifo_count [NUM_VC];

  logic [CRD_W-1:0]   credit [NUM_VC];
  logic [NUM_VC-1:0]  crd_ret_c;
  logic               crd_ovf_c;
  logic               fifo_ovf_c;
  logic [NUM_VC-1:0]  vc_elig;

  logic [VC_BITS-1:0] rr_ptr;
  logic [31:0]        rr_idx_c;
  logic               gnt_vld_c;
  logic [VC_BITS-1:0] gnt_vc_c;

  logic               link_valid;
  logic [VC_BITS-1:0] link_vc;
  logic [FLIT_W-1:0]  link_flit;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    flit_fifo #(
      .FLIT_W     (FLIT_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr        (fifo_wr[v]),
      .wr_data   (bus.tr_flit),
      .rd        (fifo_rd[v]),
      .rd_data_c (fifo_data[v]),
      .full      (fifo_full[v]),
      .empty     (fifo_empty[v]),
      .count     (fifo_count[v])
    );
  end

  // Per-VC write/pop/credit decode
  always_comb begin
    all_room_c = 1'b1;
    crd_ovf_c  = 1'b0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      if (fifo_count[v] == CNT_W'(FIFO_DEPTH)) all_room_c = 1'b0;
      fifo_wr[v]   = (state == ST_WAIT) && bus.tr_flit_vld && (bus.tr_vc == VC_BITS'(v));
      fifo_rd[v]   = gnt_vld_c && (gnt_vc_c == VC_BITS'(v));
      crd_ret_c[v] = bus.credit_in && (bus.credit_vc == VC_BITS'(v));
      vc_elig[v]   = !fifo_empty[v] && (credit[v] != CRD_W'(0));
      if (crd_ret_c[v] && !fifo_rd[v] && (credit[v] == CRD_MAX)) crd_ovf_c = 1'b1;
    end
    fifo_ovf_c = |(fifo_wr & fifo_full & ~fifo_rd);
  end

  // Dequeue FSM: one outstanding request, WAIT lasts exactly one cycle
  always_comb begin
    state_nxt    = state;
    tr_deq_nxt   = 1'b0;
    stray_flit_c = 1'b0;
    case (state)
      ST_IDLE: begin
        stray_flit_c = bus.tr_flit_vld;
        if (enable && bus.tr_pending && all_room_c) begin
          state_nxt  = ST_WAIT;
          tr_deq_nxt = 1'b1;
        end
      end
      ST_WAIT: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      tr_deq <= 1'b0;
    end else begin
      state  <= state_nxt;
      tr_deq <= tr_deq_nxt;
    end
  end

  // Round-robin search starting one past the last grant
  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_vc_c  = '0;
    rr_idx_c  = '0;
    for (int unsigned i = 1; i <= NUM_VC; i++) begin
      rr_idx_c = (32'(rr_ptr) + i) % NUM_VC;
      if (!gnt_vld_c && vc_elig[VC_BITS'(rr_idx_c)]) begin
        gnt_vld_c = 1'b1;
        gnt_vc_c  = VC_BITS'(rr_idx_c);
      end
    end
  end

  // Send and return on the same VC cancel; a return at full credit is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned v = 0; v < NUM_VC; v++) credit[v] <= CRD_MAX;
    end else begin
      for (int unsigned v = 0; v < NUM_VC; v++) begin
        if (fifo_rd[v] && !crd_ret_c[v]) begin
          credit[v] <= credit[v] - CRD_W'(1);
        end else if (crd_ret_c[v] && !fifo_rd[v] && (credit[v] != CRD_MAX)) begin
          credit[v] <= credit[v] + CRD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= VC_BITS'(NUM_VC - 1);
      link_valid <= 1'b0;
      link_vc    <= '0;
      link_flit  <= '0;
      flits_sent <= '0;
      err        <= 1'b0;
    end else begin
      link_valid <= gnt_vld_c;
      if (gnt_vld_c) begin
        rr_ptr     <= gnt_vc_c;
        link_vc    <= gnt_vc_c;
        link_flit  <= fifo_data[gnt_vc_c];
        flits_sent <= flits_sent + 16'd1;
      end
      err <= err | stray_flit_c | crd_ovf_c | fifo_ovf_c;
    end
  end

  assign bus.tr_deq     = tr_deq;
  assign bus.link_valid = link_valid;
  assign bus.link_vc    = link_vc;
  assign bus.link_flit  = link_flit;

endmodule
